vs_sensing_matrix_sequencer: RTL

Top-level sequencer for the sensing matrix processor in the greedy-recovery loop. On a host start it can first order a sensing-matrix load. It then runs K iterations. Each iteration:

- commands an inner-product pass over all columns;
- scans the resulting product RAM for the column of largest absolute correlation;
- writes that column index into the support list;
- hands off to the external residual-update block and waits for it to finish.

The block owns all command/start sequencing of the processor; nothing else drives its `command`/`start`.

---
 rtl/vs_sensing_matrix_sequencer.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vs_sensing_matrix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vs_sensing_matrix_sequencer (with vs_sensing_matrix_pkg)
// Purpose  : Top-level command sequencer for the sensing matrix processor in
//            the greedy-recovery loop.
//
//            On a host start it can first order a sensing-matrix load. It then
//            runs k iterations. Each iteration does the following:
//              1. Commands an inner-product pass.
//              2. Scans the product RAM for the column with the largest
//                 absolute correlation.
//              3. Writes that column into the support list.
//              4. Hands off to the residual-update block and waits for it.
//
// Options  : VS_SEQ_EXCLUDE_SELECTED_EN - when defined, columns that were
//            already selected are masked out of later scans. The mask is a
//            COLUMNS-bit bitmap.
//
// Ports    : clock, reset_n (sync, active-low)
//            start / load_matrix / sparsity_k     host request
//            busy / done                          host status
//            smp_command / smp_start / smp_done   processor handshake
//            prod_read_addr / prod_read_data      product RAM read port
//                                                 (1-cycle read latency)
//            support_write_enable / _addr / support_index, best_magnitude
//            res_update_start / res_update_done   residual-update handshake
//
// Revision : 1.0 - initial release
// ============================================================================

package vs_sensing_matrix_pkg;
    localparam int FP_DATA_BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        COMPUTE_INNER_PRODUCTS = 2'd0,
        LOAD_SENSING_MATRIX    = 2'd1
    } vs_sensing_matrix_command_t;
endpackage

module vs_sensing_matrix_sequencer
    import vs_sensing_matrix_pkg::*;
#(
    parameter int COLUMNS = 256,
    parameter int MAX_K   = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             load_matrix,
    input  logic [7:0]                       sparsity_k,
    output logic                             busy,
    output logic                             done,
    output vs_sensing_matrix_command_t       smp_command,
    output logic                             smp_start,
    input  logic                             smp_done,
    output logic [7:0]                       prod_read_addr,
    input  logic [FP_DATA_BUS_WIDTH-1:0]     prod_read_data,
    output logic                             support_write_enable,
    output logic [7:0]                       support_write_addr,
    output logic [7:0]                       support_index,
    output logic [FP_DATA_BUS_WIDTH-1:0]     best_magnitude,
    output logic                             res_update_start,
    input  logic                             res_update_done
);

    localparam logic [3:0] c_ST_IDLE          = 4'd0;
    localparam logic [3:0] c_ST_LOAD_REQ      = 4'd1;
    localparam logic [3:0] c_ST_LOAD_WAIT     = 4'd2;
    localparam logic [3:0] c_ST_IP_REQ        = 4'd3;
    localparam logic [3:0] c_ST_IP_WAIT       = 4'd4;
    localparam logic [3:0] c_ST_SCAN          = 4'd5;
    localparam logic [3:0] c_ST_SCAN_DRAIN    = 4'd6;
    localparam logic [3:0] c_ST_SUPPORT_WRITE = 4'd7;
    localparam logic [3:0] c_ST_RES_REQ       = 4'd8;
    localparam logic [3:0] c_ST_RES_WAIT      = 4'd9;
    localparam logic [3:0] c_ST_FINISH        = 4'd10;

    localparam logic [7:0] c_LAST_ADDR = 8'(COLUMNS - 1);
    localparam logic [7:0] c_MAX_K     = 8'(MAX_K);
    localparam logic [FP_DATA_BUS_WIDTH-1:0] c_MOST_NEG =
        {1'b1, {(FP_DATA_BUS_WIDTH-1){1'b0}}};
    localparam logic [FP_DATA_BUS_WIDTH-1:0] c_MAX_POS =
        {1'b0, {(FP_DATA_BUS_WIDTH-1){1'b1}}};

    logic [3:0]                   r_state;
    logic [3:0]                   w_state_next;
    logic [7:0]                   r_k;
    logic [7:0]                   r_it;
    logic [7:0]                   w_k_clamped;
    logic                         w_start_accept;

    // Read pipeline: r_rd_valid marks that prod_read_data holds the word
    // addressed one cycle earlier. r_rd_idx holds that address.
    logic                         r_rd_valid;
    logic [7:0]                   r_rd_idx;

    logic [FP_DATA_BUS_WIDTH-1:0] r_best_mag;
    logic [7:0]                   r_best_idx;
    logic [FP_DATA_BUS_WIDTH-1:0] w_abs;
    logic                         w_masked;
    logic                         w_take;
    logic [FP_DATA_BUS_WIDTH-1:0] w_best_mag_nxt;
    logic [7:0]                   w_best_idx_nxt;
    logic                         w_scan_entry;

    assign w_k_clamped    = (sparsity_k > c_MAX_K) ? c_MAX_K : sparsity_k;
    assign w_start_accept = (r_state == c_ST_IDLE) && start;
    assign w_scan_entry   = (r_state == c_ST_IP_WAIT) && (w_state_next == c_ST_SCAN);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (load_matrix)
                        w_state_next = c_ST_LOAD_REQ;
                    else if (w_k_clamped == 8'd0)
                        w_state_next = c_ST_FINISH;
                    else
                        w_state_next = c_ST_IP_REQ;
                end
            end
            c_ST_LOAD_REQ:  w_state_next = c_ST_LOAD_WAIT;
            c_ST_LOAD_WAIT: begin
                if (smp_done)
                    w_state_next = (r_k == 8'd0) ? c_ST_FINISH : c_ST_IP_REQ;
            end
            c_ST_IP_REQ:    w_state_next = c_ST_IP_WAIT;
            c_ST_IP_WAIT: begin
                if (smp_done)
                    w_state_next = c_ST_SCAN;
            end
            c_ST_SCAN: begin
                if (prod_read_addr == c_LAST_ADDR)
                    w_state_next = c_ST_SCAN_DRAIN;
            end
            c_ST_SCAN_DRAIN:    w_state_next = c_ST_SUPPORT_WRITE;
            c_ST_SUPPORT_WRITE: w_state_next = c_ST_RES_REQ;
            c_ST_RES_REQ:       w_state_next = c_ST_RES_WAIT;
            c_ST_RES_WAIT: begin
                if (res_update_done)
                    w_state_next = ((r_it + 8'd1) == r_k) ? c_ST_FINISH : c_ST_IP_REQ;
            end
            c_ST_FINISH:        w_state_next = c_ST_IDLE;
            default:            w_state_next = c_ST_IDLE;
        endcase
    end

    // Magnitude of the returning word. The most negative value has no
    // positive twin, so it saturates to the largest positive value.
    always_comb begin
        w_abs = prod_read_data;
        if (prod_read_data[FP_DATA_BUS_WIDTH-1]) begin
            if (prod_read_data == c_MOST_NEG)
                w_abs = c_MAX_POS;
            else
                w_abs = -prod_read_data;
        end
    end

`ifdef VS_SEQ_EXCLUDE_SELECTED_EN
    logic [COLUMNS-1:0] r_selected;

    assign w_masked = r_selected[r_rd_idx];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_selected <= '0;
        end else if (w_start_accept) begin
            r_selected <= '0;
        end else if (r_state == c_ST_SUPPORT_WRITE) begin
            r_selected[support_index] <= 1'b1;
        end
    end
`else
    assign w_masked = 1'b0;
`endif

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        w_take         = r_rd_valid && !w_masked && (w_abs > r_best_mag);
        w_best_mag_nxt = w_take ? w_abs    : r_best_mag;
        w_best_idx_nxt = w_take ? r_rd_idx : r_best_idx;
    end

    // State, datapath and registered outputs. Each output is decoded from
    // the next state, so it is valid in the first cycle of that state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state              <= c_ST_IDLE;
            r_k                  <= 8'd0;
            r_it                 <= 8'd0;
            r_rd_valid           <= 1'b0;
            r_rd_idx             <= 8'd0;
            r_best_mag           <= '0;
            r_best_idx           <= 8'd0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            smp_start            <= 1'b0;
            smp_command          <= COMPUTE_INNER_PRODUCTS;
            prod_read_addr       <= 8'd0;
            support_write_enable <= 1'b0;
            support_write_addr   <= 8'd0;
            support_index        <= 8'd0;
            best_magnitude       <= '0;
            res_update_start     <= 1'b0;
        end else begin
            r_state              <= w_state_next;
            busy                 <= (w_state_next != c_ST_IDLE);
            done                 <= (w_state_next == c_ST_FINISH);
            smp_start            <= (w_state_next == c_ST_LOAD_REQ) ||
                                    (w_state_next == c_ST_IP_REQ);
            support_write_enable <= (w_state_next == c_ST_SUPPORT_WRITE);
            res_update_start     <= (w_state_next == c_ST_RES_REQ);

            // The command changes only when a request is issued, so it stays
            // stable through the whole wait for smp_done.
            if (w_state_next == c_ST_LOAD_REQ)
                smp_command <= LOAD_SENSING_MATRIX;
            else if (w_state_next == c_ST_IP_REQ)
                smp_command <= COMPUTE_INNER_PRODUCTS;

            if (w_start_accept) begin
                r_k  <= w_k_clamped;
                r_it <= 8'd0;
            end else if ((r_state == c_ST_RES_WAIT) && res_update_done) begin
                r_it <= r_it + 8'd1;
            end

            if (w_scan_entry)
                prod_read_addr <= 8'd0;
            else if ((r_state == c_ST_SCAN) && (w_state_next == c_ST_SCAN))
                prod_read_addr <= prod_read_addr + 8'd1;

            r_rd_valid <= (r_state == c_ST_SCAN);
            r_rd_idx   <= prod_read_addr;

            if (w_scan_entry) begin
                r_best_mag <= '0;
                r_best_idx <= 8'd0;
            end else begin
                r_best_mag <= w_best_mag_nxt;
                r_best_idx <= w_best_idx_nxt;
            end

            // Use the post-compare values so that the word still draining
            // in this cycle is included in the selection.
            if (w_state_next == c_ST_SUPPORT_WRITE) begin
                support_write_addr <= r_it;
                support_index      <= w_best_idx_nxt;
                best_magnitude     <= w_best_mag_nxt;
            end
        end
    end

endmodule
`default_nettype wire
